// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT sequencing controller.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT pair/twiddle address generator: p is k with a zero bit inserted at
// position s, q sets that bit, tw scales the low s bits of k up to the ROM range.
module fft_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-2:0] k,
  input  logic [2:0]            s,
  output logic [ADDR_WIDTH-1:0] p,
  output logic [ADDR_WIDTH-1:0] q,
  output logic [ADDR_WIDTH-2:0] tw
);

  localparam logic [2:0] TW_TOP = 3'(ADDR_WIDTH-1);

  logic [ADDR_WIDTH-2:0] w_mask;
  logic [ADDR_WIDTH-2:0] w_lo;
  logic [ADDR_WIDTH-2:0] w_hi;

  assign w_mask = ~({(ADDR_WIDTH-1){1'b1}} << s);
  assign w_lo   = k & w_mask;
  assign w_hi   = k & ~w_mask;

  assign p  = {w_hi, 1'b0} | {1'b0, w_lo};
  assign q  = p | (ADDR_WIDTH'(1) << s);
  assign tw = w_lo << (TW_TOP - s);

endmodule

// File: rtl/fft_seq_ctrl.sv
// In-place radix-2 FFT sequencer: walks stages/pairs, issues RAM reads, and
// replays the read addresses as write-backs after the butterfly latency.
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BFLY_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            stage,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_p,
  output logic [ADDR_WIDTH-1:0] rd_addr_q,
  output logic [ADDR_WIDTH-2:0] tw_addr,
  output logic                  bfly_valid,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr_p,
  output logic [ADDR_WIDTH-1:0] wr_addr_q
);

  localparam int KW  = ADDR_WIDTH - 1;
  localparam int DLY = RD_LAT + BFLY_LAT;
  localparam int DW  = $clog2(DLY + 1);

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [2:0]    S_LAST = 3'(ADDR_WIDTH - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DLY - 1);

  state_e          r_state;
  logic [KW-1:0]   r_k;
  logic [2:0]      r_stage;
  logic [DW-1:0]   r_dcnt;
  logic            r_rd_en;
  logic            r_busy;
  logic            r_done;

  logic [DLY:1]                 r_vld_pipe;
  logic [DLY:1][ADDR_WIDTH-1:0] r_p_pipe;
  logic [DLY:1][ADDR_WIDTH-1:0] r_q_pipe;

  logic [ADDR_WIDTH-1:0] w_p;
  logic [ADDR_WIDTH-1:0] w_q;
  logic [KW-1:0]         w_tw;

  fft_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .k  (r_k),
    .s  (r_stage),
    .p  (w_p),
    .q  (w_q),
    .tw (w_tw)
  );

  // Counters hold their last value outside READ, so addresses are gated to zero.
  assign rd_en      = r_rd_en;
  assign rd_addr_p  = r_rd_en ? w_p  : '0;
  assign rd_addr_q  = r_rd_en ? w_q  : '0;
  assign tw_addr    = r_rd_en ? w_tw : '0;
  assign stage      = r_stage;
  assign busy       = r_busy;
  assign done       = r_done;
  assign bfly_valid = r_vld_pipe[1];
  assign wr_en      = r_vld_pipe[DLY];
  assign wr_addr_p  = r_p_pipe[DLY];
  assign wr_addr_q  = r_q_pipe[DLY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_dcnt  <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_READ;
            r_k     <= '0;
            r_stage <= '0;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          if (r_k == K_LAST) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
            r_dcnt  <= '0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          // Exit lands on the last write of the stage, so the next read cannot race it.
          if (r_dcnt == D_LAST) begin
            if (r_stage == S_LAST) begin
              r_state <= S_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
              r_stage <= r_stage + 3'd1;
              r_k     <= '0;
              r_rd_en <= 1'b1;
            end
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_stage <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_rd_en <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_p_pipe   <= '0;
      r_q_pipe   <= '0;
    end else if (abort) begin
      r_vld_pipe <= '0;
      r_p_pipe   <= '0;
      r_q_pipe   <= '0;
    end else begin
      r_vld_pipe[1] <= r_rd_en;
      r_p_pipe[1]   <= rd_addr_p;
      r_q_pipe[1]   <= rd_addr_q;
      for (int i = 2; i <= DLY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_p_pipe[i]   <= r_p_pipe[i-1];
        r_q_pipe[i]   <= r_q_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Bench for fft_seq_ctrl: records every cycle of a run, then compares against
// a schedule computed arithmetically from stage/pair timing.
module tb_fft_seq_ctrl;

  localparam int AW     = 8;
  localparam int BL     = 4;
  localparam int TWW    = AW - 1;
  localparam int NH     = 1 << (AW - 1);
  localparam int NS     = AW;
  localparam int PER    = NH + 1 + BL;
  localparam int LAST_WR = NS * PER;
  localparam int DONE_C = LAST_WR + 1;
  localparam int MAXC   = 1100;

  typedef struct packed {
    logic           rd_en;
    logic [AW-1:0]  rp;
    logic [AW-1:0]  rq;
    logic [TWW-1:0] tw;
    logic [2:0]     stg;
    logic           bv;
    logic           wr_en;
    logic [AW-1:0]  wp;
    logic [AW-1:0]  wq;
    logic           busy;
    logic           done;
  } sig_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic           busy;
  logic           done;
  logic [2:0]     stage;
  logic           rd_en;
  logic [AW-1:0]  rd_addr_p;
  logic [AW-1:0]  rd_addr_q;
  logic [TWW-1:0] tw_addr;
  logic           bfly_valid;
  logic           wr_en;
  logic [AW-1:0]  wr_addr_p;
  logic [AW-1:0]  wr_addr_q;

  sig_t obs [0:MAXC];
  sig_t obs_rst;
  int   total;
  int   bad;

  fft_seq_ctrl #(.ADDR_WIDTH(AW), .BFLY_LAT(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .stage      (stage),
    .rd_en      (rd_en),
    .rd_addr_p  (rd_addr_p),
    .rd_addr_q  (rd_addr_q),
    .tw_addr    (tw_addr),
    .bfly_valid (bfly_valid),
    .wr_en      (wr_en),
    .wr_addr_p  (wr_addr_p),
    .wr_addr_q  (wr_addr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic sig_t sample();
    sig_t s;
    s.rd_en = rd_en;    s.rp = rd_addr_p; s.rq = rd_addr_q; s.tw = tw_addr;
    s.stg   = stage;    s.bv = bfly_valid; s.wr_en = wr_en;
    s.wp    = wr_addr_p; s.wq = wr_addr_q; s.busy = busy; s.done = done;
    return s;
  endfunction

  // Address fields are don't-care while their enable is low.
  function automatic sig_t mask(input sig_t x);
    sig_t y = x;
    if (!y.rd_en) begin y.rp = '0; y.rq = '0; y.tw = '0; y.stg = '0; end
    if (!y.wr_en) begin y.wp = '0; y.wq = '0; end
    return y;
  endfunction

  // Which (stage, pair) is read at cycle c of an unbroken run (start at cycle 0).
  function automatic void rd_slot(input int c, output bit v, output int s, output int k);
    v = 1'b0; s = 0; k = 0;
    if (c >= 1 && c <= NS * PER) begin
      s = (c - 1) / PER;
      k = (c - 1) % PER;
      v = (k < NH);
    end
  endfunction

  function automatic int pair_p(input int s, input int k);
    int half = 1 << s;
    return (k / half) * 2 * half + (k % half);
  endfunction

  function automatic sig_t ref_at(input int c, input int cut);
    sig_t e = '0;
    bit v; int s, k;
    if (cut > 0 && c > cut) return e;
    rd_slot(c, v, s, k);
    if (v) begin
      e.rd_en = 1'b1;
      e.stg   = 3'(s);
      e.rp    = AW'(pair_p(s, k));
      e.rq    = AW'(pair_p(s, k) + (1 << s));
      e.tw    = TWW'((k % (1 << s)) * (NH / (1 << s)));
    end
    rd_slot(c - 1, v, s, k);
    e.bv = v;
    rd_slot(c - 1 - BL, v, s, k);
    if (v) begin
      e.wr_en = 1'b1;
      e.wp    = AW'(pair_p(s, k));
      e.wq    = AW'(pair_p(s, k) + (1 << s));
    end
    e.busy = (c >= 1 && c <= LAST_WR);
    e.done = (c == DONE_C);
    return mask(e);
  endfunction

  // Pulses start in cycle 0 and records cycles 0..ncyc; a zero argument disables that event.
  task automatic run_seq(input int ncyc, input int abort_at, input int xs1, input int xs2,
                         input int rst_at);
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0;
    obs[0] = sample();
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      obs[c] = sample();
      start = (c == xs1) || (c == xs2);
      abort = (c == abort_at);
      if (rst_at > 0 && c == rst_at) begin
        rst_n = 1'b0; #1;
        obs_rst = sample();
      end
      if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    sig_t s;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    #13;
    s = sample(); total++;
    if (s !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", s); end
    #20;
    s = sample(); total++;
    if (s !== '0) begin bad++; $display("FAIL reset_hold_start got=%h exp=0", s); end
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      s = mask(sample()); total++;
      if (s !== '0) begin bad++; $display("FAIL reset_idle i=%0d got=%h exp=0", i, s); end
    end
  endtask

  task automatic test_idle_abort_start();
    sig_t s;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = mask(sample()); total++;
      if (s !== '0) begin bad++; $display("FAIL abort_start_idle i=%0d got=%h exp=0", i, s); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_run();
    sig_t e;
    int   n = DONE_C + 5;
    int   nrd = 0, nwr = 0, nbusy = 0, done_at = -1, ndone = 0, last_wr = -1, nbound = 0;
    run_seq(n, 0, 0, 0, 0);
    for (int c = 0; c <= n; c++) begin
      e = ref_at(c, 0); total++;
      if (mask(obs[c]) !== e) begin
        bad++; $display("FAIL full_run c=%0d got=%h exp=%h", c, mask(obs[c]), e);
      end
      if (c > 1 && obs[c].rd_en && !obs[c-1].rd_en) begin
        nbound++; total++;
        if (c !== last_wr + 1) begin
          bad++; $display("FAIL stage_boundary first_rd=%0d last_wr=%0d", c, last_wr);
        end
      end
      if (obs[c].rd_en) nrd++;
      if (obs[c].wr_en) begin nwr++; last_wr = c; end
      if (obs[c].busy) nbusy++;
      if (obs[c].done) begin ndone++; done_at = c; end
    end
    total++; if (nrd !== NS * NH) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", nrd, NS * NH); end
    total++; if (nwr !== NS * NH) begin bad++; $display("FAIL wr_count got=%0d exp=%0d", nwr, NS * NH); end
    total++; if (nbusy !== LAST_WR) begin bad++; $display("FAIL busy_cycles got=%0d exp=%0d", nbusy, LAST_WR); end
    total++; if (ndone !== 1 || done_at !== 1065) begin
      bad++; $display("FAIL done_cycle got=%0d count=%0d exp=1065", done_at, ndone);
    end
    total++; if (nbound !== NS - 1) begin bad++; $display("FAIL boundary_count got=%0d exp=%0d", nbound, NS - 1); end
    total++; if ({obs[1].rp, obs[1].rq, obs[1].tw} !== {8'd0, 8'd1, 7'd0}) begin
      bad++; $display("FAIL addr_s0_k0 got=%h exp=%h", {obs[1].rp, obs[1].rq, obs[1].tw}, {8'd0, 8'd1, 7'd0});
    end
    total++; if ({obs[135].rp, obs[135].rq, obs[135].tw} !== {8'd1, 8'd3, 7'd64}) begin
      bad++; $display("FAIL addr_s1_k1 got=%h exp=%h", {obs[135].rp, obs[135].rq, obs[135].tw}, {8'd1, 8'd3, 7'd64});
    end
    total++; if ({obs[1059].rp, obs[1059].rq, obs[1059].tw} !== {8'd127, 8'd255, 7'd127}) begin
      bad++; $display("FAIL addr_s7_k127 got=%h exp=%h", {obs[1059].rp, obs[1059].rq, obs[1059].tw}, {8'd127, 8'd255, 7'd127});
    end
  endtask

  task automatic test_abort();
    sig_t e;
    int   a, nd;
    for (int r = 0; r < 2; r++) begin
      a = (r == 0) ? 500 : int'($urandom_range(2, 1060));
      run_seq(a + 30, a, 0, 0, 0);
      nd = 0;
      for (int c = 0; c <= a + 30; c++) begin
        e = ref_at(c, a); total++;
        if (mask(obs[c]) !== e) begin
          bad++; $display("FAIL abort a=%0d c=%0d got=%h exp=%h", a, c, mask(obs[c]), e);
        end
        if (obs[c].done) nd++;
      end
      total++;
      if (nd !== 0) begin bad++; $display("FAIL abort_no_done a=%0d got=%0d exp=0", a, nd); end
    end
  endtask

  task automatic test_back_to_back();
    sig_t e;
    int   n = DONE_C + 3;
    run_seq(n, 0, 0, 0, 0);
    for (int c = 0; c <= n; c++) begin
      e = ref_at(c, 0); total++;
      if (mask(obs[c]) !== e) begin
        bad++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, mask(obs[c]), e);
      end
    end
  endtask

  task automatic test_start_ignored();
    sig_t e;
    int   x1, x2, nd;
    int   n = DONE_C + 5;
    for (int r = 0; r < 2; r++) begin
      x1 = (r == 0) ? 10  : int'($urandom_range(1, LAST_WR));
      x2 = (r == 0) ? 700 : int'($urandom_range(1, LAST_WR));
      run_seq(n, 0, x1, x2, 0);
      nd = 0;
      for (int c = 0; c <= n; c++) begin
        e = ref_at(c, 0); total++;
        if (mask(obs[c]) !== e) begin
          bad++; $display("FAIL start_ignored x=%0d,%0d c=%0d got=%h exp=%h", x1, x2, c, mask(obs[c]), e);
        end
        if (obs[c].done) nd++;
      end
      total++;
      if (nd !== 1) begin bad++; $display("FAIL start_ignored_done got=%0d exp=1", nd); end
    end
  endtask

  task automatic test_reset_mid();
    sig_t e;
    run_seq(310, 0, 0, 0, 300);
    total++;
    if (obs_rst !== '0) begin bad++; $display("FAIL reset_mid_immediate got=%h exp=0", obs_rst); end
    for (int c = 0; c <= 310; c++) begin
      e = ref_at(c, 300); total++;
      if (mask(obs[c]) !== e) begin
        bad++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, mask(obs[c]), e);
      end
    end
    run_seq(DONE_C + 2, 0, 0, 0, 0);
    for (int c = 0; c <= DONE_C + 2; c++) begin
      e = ref_at(c, 0); total++;
      if (mask(obs[c]) !== e) begin
        bad++; $display("FAIL reset_rerun c=%0d got=%h exp=%h", c, mask(obs[c]), e);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    test_reset();
    test_idle_abort_start();
    test_full_run();
    test_abort();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, log2 of FFT length N (N=256).
REQ-002 SHALL have parameter BFLY_LAT, default 4, butterfly pipeline latency in cycles from input valid to output valid.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to transform the working RAM contents.
REQ-006 SHALL have port abort, input, 1, synchronous cancel of a running transform.
REQ-007 SHALL have port busy, output, 1, high from the first read through the final write.
REQ-008 SHALL have port done, output, 1, one-cycle pulse after the final write of the last stage.
REQ-009 SHALL have port stage, output, 3, current read stage index 0..ADDR_WIDTH-1.
REQ-010 SHALL have ports rd_en (1), rd_addr_p (ADDR_WIDTH) and rd_addr_q (ADDR_WIDTH), outputs, dual-port RAM read request and pair addresses.
REQ-011 SHALL have port tw_addr, output, ADDR_WIDTH-1, twiddle ROM index aligned with rd_en.
REQ-012 SHALL have port bfly_valid, output, 1, rd_en delayed one cycle (RAM read latency fixed at 1), butterfly input valid.
REQ-013 SHALL have ports wr_en (1), wr_addr_p (ADDR_WIDTH) and wr_addr_q (ADDR_WIDTH), outputs, in-place write-back request and pair addresses.

Function
REQ-014 SHALL implement FSM states IDLE, READ, DRAIN and FINISH.
REQ-015 IDLE: SHALL go to READ on start; start in any other state SHALL be ignored.
REQ-016 READ: SHALL assert rd_en for exactly N/2 consecutive cycles per stage, with pair counter k = 0..N/2-1.
REQ-017 SHALL generate addresses with half = 2^s, p = (k>>s)*2*half + (k & (half-1)), q = p + half, and tw_addr = (k & (half-1)) << (ADDR_WIDTH-1-s), giving decimation-in-time on bit-reversed input.
REQ-018 SHALL assert wr_en and wr_addr_p/q exactly 1+BFLY_LAT cycles after the matching rd_en, using a valid/address delay line.
REQ-019 DRAIN: after the last read of a stage, SHALL hold rd_en low for 1+BFLY_LAT cycles so the next stage's first read falls on the cycle after the previous last write (no RAW hazard).
REQ-020 SHALL increment stage on entering READ for each subsequent stage; after stage ADDR_WIDTH-1 the FSM SHALL enter FINISH after the final write.
REQ-021 FINISH: SHALL pulse done for one cycle, deassert busy in that same cycle, then return to IDLE.
REQ-022 With defaults, start sampled at cycle 0 SHALL give first rd_en at cycle 1, stage s reads at cycles 1+133s .. 128+133s, last wr_en at cycle 1064, and done at cycle 1065.
REQ-023 abort SHALL have priority over all other events: next cycle the FSM is IDLE and rd_en, wr_en, bfly_valid and the delay line are cleared; no done pulse SHALL be issued.
REQ-024 abort together with start in IDLE SHALL leave the FSM in IDLE.
REQ-025 The k counter and the stage counter SHALL not wrap; terminal values SHALL be detected explicitly.

Reset
REQ-026 With rst_n low, all outputs SHALL be 0, the FSM SHALL be IDLE, and all counters and the delay line SHALL be cleared, asynchronously.
REQ-027 Reset asserted mid-transform SHALL abandon it without a done pulse; after release the block SHALL be in IDLE awaiting start.

Structure
REQ-028 A package fft_ctrl_pkg SHALL hold the FSM state enum and the RD_LAT=1 constant.
REQ-029 Address/twiddle generation SHALL be one combinational sub-module, fft_addr_gen(k, s) -> p, q, tw.

Verification
REQ-030 Single run, defaults: start pulse -> rd_en count 1024, wr_en count 1024, done exactly at cycle 1065, busy high cycles 1..1064.
REQ-031 Address check: stage 0 k=0 -> p=0, q=1, tw=0; stage 1 k=1 -> p=1, q=3, tw=64; stage 7 k=127 -> p=127, q=255, tw=127.
REQ-032 Hazard check: at every stage boundary, the first read of the next stage occurs exactly 1 cycle after the previous last wr_en; each wr_addr pair equals the rd_addr pair from 5 cycles earlier.
REQ-033 Abort at cycle 500 (stage 3) -> cycle 501 IDLE, rd_en=wr_en=0, no done; a following start runs a full 1065-cycle transform.
REQ-034 start pulsed at cycles 10 and 700 during a run -> ignored; exactly one done at cycle 1065.
REQ-035 rst_n low at cycle 300 -> outputs 0 immediately; release then start -> normal run with done 1065 cycles after start.
